// File: rtl/segment_link_rx.sv
// segment_link_rx: receiver for the 3-wire Sftclk/Lchclk/SDout shift-and-latch serial link.
//
// Oversamples the link wires on clk, shifts SD in MSB first on each Sftclk rise,
// and on each Lchclk rise either publishes the word (dout_rdy pulse) or flags a
// badly framed word (frame_err pulse, err_cnt++).
//
// Optional feature macro: SR_RX_TIMEOUT_EN -- drop a partial frame after
// TIMEOUT_CYC clk cycles without any link edge.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous reset, active low
//   sftclk_in  link shift clock (asynchronous)
//   lchclk_in  link latch clock (asynchronous)
//   sd_in      link serial data (asynchronous)
//   dout       last correctly framed word
//   dout_rdy   1-cycle pulse, dout updated
//   frame_err  1-cycle pulse, short/long/empty/timed-out frame
//   err_cnt    saturating count of frame_err pulses
//   busy       high while a frame is being shifted in
module segment_link_rx #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sftclk_in,
    input  logic             lchclk_in,
    input  logic             sd_in,
    output logic [WIDTH-1:0] dout,
    output logic             dout_rdy,
    output logic             frame_err,
    output logic [7:0]       err_cnt,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);
    localparam logic [CW-1:0] OVER = CW'(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] sft_sync_q, lch_sync_q, sd_sync_q;
    logic                   sft_hist_q, lch_hist_q;
    logic                   sft_rise, lch_rise, sd_sync;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d, dout_q, dout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       ecnt_q, ecnt_d;
    logic             rdy_q, rdy_d, err_q, err_d, busy_q;

`ifdef SR_RX_TIMEOUT_EN
    localparam int IW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [IW-1:0] TO_LAST = IW'(TIMEOUT_CYC - 1);
    logic [IW-1:0] idle_q, idle_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    assign sft_rise = sft_sync_q[SYNC_STAGES-1] & ~sft_hist_q;
    assign lch_rise = lch_sync_q[SYNC_STAGES-1] & ~lch_hist_q;
    assign sd_sync  = sd_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        ecnt_d  = ecnt_q;
        rdy_d   = 1'b0;
        err_d   = 1'b0;
        // Latch evaluates the pre-shift frame even when a shift arrives in the same cycle.
        if (lch_rise) begin
            if (cnt_q == FULL) begin
                dout_d = shift_q;
                rdy_d  = 1'b1;
            end else begin
                err_d = 1'b1;
            end
            cnt_d   = '0;
            state_d = IDLE;
        end
        // A shift always leaves us in SHIFT; coincident with a latch it opens the next frame.
        if (sft_rise) begin
            shift_d = {shift_q[WIDTH-2:0], sd_sync};
            cnt_d   = (lch_rise || state_q == IDLE) ? CW'(1) :
                      (cnt_q == OVER) ? OVER : cnt_q + CW'(1);
            state_d = SHIFT;
        end
`ifdef SR_RX_TIMEOUT_EN
        idle_d = idle_q;
        if (sft_rise || lch_rise || state_q == IDLE) begin
            idle_d = '0;
        end else if (idle_q == TO_LAST) begin
            idle_d  = '0;
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
        end else begin
            idle_d = idle_q + IW'(1);
        end
`endif
        if (err_d && ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sft_sync_q <= '0;
            lch_sync_q <= '0;
            sd_sync_q  <= '0;
            sft_hist_q <= 1'b0;
            lch_hist_q <= 1'b0;
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            dout_q     <= '0;
            ecnt_q     <= '0;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
`ifdef SR_RX_TIMEOUT_EN
            idle_q     <= '0;
`endif
        end else begin
            sft_sync_q <= {sft_sync_q[SYNC_STAGES-2:0], sftclk_in};
            lch_sync_q <= {lch_sync_q[SYNC_STAGES-2:0], lchclk_in};
            sd_sync_q  <= {sd_sync_q[SYNC_STAGES-2:0], sd_in};
            sft_hist_q <= sft_sync_q[SYNC_STAGES-1];
            lch_hist_q <= lch_sync_q[SYNC_STAGES-1];
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            ecnt_q     <= ecnt_d;
            rdy_q      <= rdy_d;
            err_q      <= err_d;
            busy_q     <= (state_d == SHIFT);
`ifdef SR_RX_TIMEOUT_EN
            idle_q     <= idle_d;
`endif
        end
    end

    assign dout      = dout_q;
    assign dout_rdy  = rdy_q;
    assign frame_err = err_q;
    assign err_cnt   = ecnt_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_segment_link_rx.sv
// tb_segment_link_rx: directed self-checking bench for segment_link_rx.
module tb_segment_link_rx;
    logic        clk = 0, rst_n = 0, sft = 0, lch = 0, sd = 0;
    logic [15:0] dout;
    logic        dout_rdy, frame_err, busy;
    logic [7:0]  err_cnt;
    int vectors = 0, miscompares = 0;
    int n_rdy = 0, n_err = 0, n_both = 0;
    int r0, e0;
    logic [7:0] exp_ecnt = 0;

    segment_link_rx #(.WIDTH(16), .SYNC_STAGES(2), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst_n(rst_n), .sftclk_in(sft), .lchclk_in(lch), .sd_in(sd),
        .dout(dout), .dout_rdy(dout_rdy), .frame_err(frame_err),
        .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // Count high cycles of each strobe, sampled just after the active edge.
    always @(posedge clk) begin
        #1;
        if (dout_rdy) n_rdy++;
        if (frame_err) n_err++;
        if (dout_rdy && frame_err) n_both++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sft = 0; lch = 0; sd = b;
        wait_cyc(3);
        sft = 1;
        wait_cyc(3);
    endtask

    task automatic send_word(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic latch();
        sft = 0; lch = 1;
        wait_cyc(3);
        lch = 0;
        wait_cyc(3);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mark();
        r0 = n_rdy; e0 = n_err;
    endtask

    task automatic test_reset();
        rst_n = 0;
        wait_cyc(3);
        if (dout !== 16'h0) begin miscompares++; $display("FAIL reset_dout: got %h expected 0", dout); end vectors++;
        if (dout_rdy !== 1'b0) begin miscompares++; $display("FAIL reset_rdy: got %b expected 0", dout_rdy); end vectors++;
        if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", frame_err); end vectors++;
        if (err_cnt !== 8'h0) begin miscompares++; $display("FAIL reset_errcnt: got %h expected 0", err_cnt); end vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end vectors++;
        rst_n = 1;
        wait_cyc(3);
    endtask

    task automatic test_good_frame();
        mark();
        send_word(32'hA53C, 16);
        if (busy !== 1'b1) begin miscompares++; $display("FAIL good_busy: got %b expected 1", busy); end vectors++;
        latch();
        if (dout !== 16'hA53C) begin miscompares++; $display("FAIL good_dout: got %h expected a53c", dout); end vectors++;
        if (n_rdy - r0 !== 1) begin miscompares++; $display("FAIL good_rdy_cycles: got %0d expected 1", n_rdy - r0); end vectors++;
        if (n_err - e0 !== 0) begin miscompares++; $display("FAIL good_err_cycles: got %0d expected 0", n_err - e0); end vectors++;
        if (err_cnt !== exp_ecnt) begin miscompares++; $display("FAIL good_errcnt: got %0d expected %0d", err_cnt, exp_ecnt); end vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL good_idle: got %b expected 0", busy); end vectors++;
    endtask

    task automatic test_short_long();
        mark();
        send_word(32'h1FFF, 15);
        latch();
        exp_ecnt++;
        if (n_err - e0 !== 1) begin miscompares++; $display("FAIL short_err_cycles: got %0d expected 1", n_err - e0); end vectors++;
        if (n_rdy - r0 !== 0) begin miscompares++; $display("FAIL short_rdy: got %0d expected 0", n_rdy - r0); end vectors++;
        if (dout !== 16'hA53C) begin miscompares++; $display("FAIL short_dout: got %h expected a53c", dout); end vectors++;
        if (err_cnt !== exp_ecnt) begin miscompares++; $display("FAIL short_errcnt: got %0d expected %0d", err_cnt, exp_ecnt); end vectors++;
        mark();
        send_word(32'h1_5555, 17);
        latch();
        exp_ecnt++;
        if (n_err - e0 !== 1) begin miscompares++; $display("FAIL long_err_cycles: got %0d expected 1", n_err - e0); end vectors++;
        if (dout !== 16'hA53C) begin miscompares++; $display("FAIL long_dout: got %h expected a53c", dout); end vectors++;
        if (err_cnt !== exp_ecnt) begin miscompares++; $display("FAIL long_errcnt: got %0d expected %0d", err_cnt, exp_ecnt); end vectors++;
    endtask

    task automatic test_back_to_back();
        mark();
        send_word(32'h1234, 16);
        sft = 0; lch = 1;
        wait_cyc(3);
        if (dout !== 16'h1234) begin miscompares++; $display("FAIL b2b_first: got %h expected 1234", dout); end vectors++;
        send_word(32'hFFFF, 16);
        latch();
        if (n_rdy - r0 !== 2) begin miscompares++; $display("FAIL b2b_rdy_cycles: got %0d expected 2", n_rdy - r0); end vectors++;
        if (n_err - e0 !== 0) begin miscompares++; $display("FAIL b2b_err_cycles: got %0d expected 0", n_err - e0); end vectors++;
        if (dout !== 16'hFFFF) begin miscompares++; $display("FAIL b2b_dout: got %h expected ffff", dout); end vectors++;
    endtask

    task automatic test_simultaneous();
        mark();
        send_word(32'h0AAA, 15);
        sft = 0; lch = 0; sd = 1'b1;
        wait_cyc(3);
        sft = 1; lch = 1;
        wait_cyc(3);
        exp_ecnt++;
        if (n_err - e0 !== 1) begin miscompares++; $display("FAIL simul_err_cycles: got %0d expected 1", n_err - e0); end vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL simul_busy: got %b expected 1", busy); end vectors++;
        if (err_cnt !== exp_ecnt) begin miscompares++; $display("FAIL simul_errcnt: got %0d expected %0d", err_cnt, exp_ecnt); end vectors++;
        send_word(32'h43A5, 15);
        latch();
        if (n_rdy - r0 !== 1) begin miscompares++; $display("FAIL simul_rdy_cycles: got %0d expected 1", n_rdy - r0); end vectors++;
        if (dout !== 16'hC3A5) begin miscompares++; $display("FAIL simul_dout: got %h expected c3a5", dout); end vectors++;
    endtask

    task automatic test_reset_mid();
        send_word(32'hA5, 8);
        sft = 0;
        wait_cyc(3);
        rst_n = 0;
        wait_cyc(3);
        if ({dout, dout_rdy, frame_err, err_cnt, busy} !== 27'h0) begin
            miscompares++; $display("FAIL midrst_outputs: got %h/%b/%b/%h/%b expected all 0", dout, dout_rdy, frame_err, err_cnt, busy);
        end
        vectors++;
        rst_n = 1;
        exp_ecnt = 0;
        wait_cyc(3);
        mark();
        send_word(32'h00FF, 16);
        latch();
        if (dout !== 16'h00FF) begin miscompares++; $display("FAIL midrst_dout: got %h expected 00ff", dout); end vectors++;
        if (err_cnt !== 8'h0) begin miscompares++; $display("FAIL midrst_errcnt: got %0d expected 0", err_cnt); end vectors++;
        if (n_rdy - r0 !== 1) begin miscompares++; $display("FAIL midrst_rdy_cycles: got %0d expected 1", n_rdy - r0); end vectors++;
    endtask

    task automatic test_timeout();
        mark();
        send_word(32'h15, 5);
        wait_cyc(80);
`ifdef SR_RX_TIMEOUT_EN
        exp_ecnt++;
        if (n_err - e0 !== 1) begin miscompares++; $display("FAIL timeout_err_cycles: got %0d expected 1", n_err - e0); end vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL timeout_busy: got %b expected 0", busy); end vectors++;
`else
        if (n_err - e0 !== 0) begin miscompares++; $display("FAIL notimeout_err_cycles: got %0d expected 0", n_err - e0); end vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL notimeout_busy: got %b expected 1", busy); end vectors++;
`endif
        latch();
        exp_ecnt++;
        if (err_cnt !== exp_ecnt) begin miscompares++; $display("FAIL timeout_errcnt: got %0d expected %0d", err_cnt, exp_ecnt); end vectors++;
    endtask

    task automatic test_err_saturate();
        mark();
        for (int i = 0; i < 260; i++) latch();
        if (n_err - e0 !== 260) begin miscompares++; $display("FAIL sat_err_cycles: got %0d expected 260", n_err - e0); end vectors++;
        if (err_cnt !== 8'hFF) begin miscompares++; $display("FAIL sat_errcnt: got %0d expected 255", err_cnt); end vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL sat_busy: got %b expected 0", busy); end vectors++;
        if (n_both !== 0) begin miscompares++; $display("FAIL strobe_overlap: got %0d expected 0", n_both); end vectors++;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_short_long();
        test_back_to_back();
        test_simultaneous();
        test_reset_mid();
        test_timeout();
        test_err_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
